fp_multiply_normalize: RTL

Downstream consumer of the 3-cycle integer multiplier's 48-bit mult_product when that multiplier is used for single-precision FP multiply: 24x24 significand product.
Two-stage pipeline:
- Stage 1 normalizes the product.
- Stage 2 rounds (round-to-nearest-even), adjusts the exponent, handles overflow/underflow and packs the IEEE-754 result.
Sign, exponent, special-case data and a tag travel alongside the product with a valid bit. Total FP multiply latency is 3+2 cycles.

---
 rtl/fp_multiply_normalize_pkg.sv | 21 ++
 rtl/fp_round_nearest_even.sv | 19 +
 rtl/fp_multiply_normalize.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fp_multiply_normalize_pkg.sv
// Shared single-precision constants and packed types used by the FP datapath blocks.
package fp_multiply_normalize_pkg;

   localparam int FLOAT32_EXP_BIAS  = 127;
   localparam int FLOAT32_EXP_MAX   = 255;
   localparam int FLOAT32_SIG_WIDTH = 23;

   typedef struct packed {
      logic                         sign;
      logic [7:0]                   exponent;
      logic [FLOAT32_SIG_WIDTH-1:0] significand;
   } float32_t;

   typedef struct packed {
      float32_t value;
      logic     overflow;
      logic     underflow;
      logic     inexact;
   } fp_pack_t;

endpackage

// File: rtl/fp_round_nearest_even.sv
// Round-to-nearest-even on a truncated significand; carry flags a wrap past the top bit.
module fp_round_nearest_even
   import fp_multiply_normalize_pkg::*;
#(
   parameter int WIDTH = FLOAT32_SIG_WIDTH
) (
   input  logic [WIDTH-1:0] mant,
   input  logic             guard,
   input  logic             sticky,
   output logic [WIDTH-1:0] mant_rounded,
   output logic             carry
);

   logic round_up;

   assign round_up = guard & (sticky | mant[0]);
   assign {carry, mant_rounded} = {1'b0, mant} + {{WIDTH{1'b0}}, round_up};

endmodule

// File: rtl/fp_multiply_normalize.sv
// Normalizes a 48-bit significand product, rounds to nearest-even and packs a float32
// result, with overflow/underflow saturation. Two register stages.
module fp_multiply_normalize
   import fp_multiply_normalize_pkg::*;
#(
   parameter int TAG_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 mul_valid,
   input  logic [47:0]          mul_product,
   input  logic signed [9:0]    mul_exponent,
   input  logic                 mul_sign,
   input  logic                 mul_special,
   input  logic [31:0]          mul_special_value,
   input  logic [TAG_WIDTH-1:0] mul_tag,
   output logic                 result_valid,
   output logic [31:0]          result,
   output logic [TAG_WIDTH-1:0] result_tag,
   output logic                 result_overflow,
   output logic                 result_underflow,
   output logic                 result_inexact
);

   function automatic fp_pack_t pack_result(input logic               sign,
                                            input logic signed [10:0] exp,
                                            input logic [22:0]        mant,
                                            input logic               inexact);
      fp_pack_t r;
      r = '0;
      if (exp >= $signed(11'(FLOAT32_EXP_MAX))) begin
         r.value    = {sign, 8'hFF, 23'h0};
         r.overflow = 1'b1;
      end else if (exp <= 11'sd0) begin
         r.value     = {sign, 31'h0};
         r.underflow = 1'b1;
      end else begin
         r.value   = {sign, exp[7:0], mant};
         r.inexact = inexact;
      end
      return r;
   endfunction

   logic                 vld_p1;
   logic [22:0]          mant_p1;
   logic                 guard_p1;
   logic                 sticky_p1;
   logic signed [10:0]   exp_p1;
   logic                 sign_p1;
   logic                 special_p1;
   logic [31:0]          special_value_p1;
   logic [TAG_WIDTH-1:0] tag_p1;

   logic                 norm_hi;
   logic signed [10:0]   exp_in;

   assign norm_hi = mul_product[47];
   assign exp_in  = {mul_exponent[9], mul_exponent};

   // Stage 1: normalize product so the implicit one sits just above mant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1           <= 1'b0;
         mant_p1          <= '0;
         guard_p1         <= 1'b0;
         sticky_p1        <= 1'b0;
         exp_p1           <= '0;
         sign_p1          <= 1'b0;
         special_p1       <= 1'b0;
         special_value_p1 <= '0;
         tag_p1           <= '0;
      end else begin
         vld_p1 <= mul_valid & ~flush;
         if (mul_valid) begin
            if (norm_hi) begin
               mant_p1   <= mul_product[46:24];
               guard_p1  <= mul_product[23];
               sticky_p1 <= |mul_product[22:0];
               exp_p1    <= exp_in + 11'sd1;
            end else begin
               mant_p1   <= mul_product[45:23];
               guard_p1  <= mul_product[22];
               sticky_p1 <= |mul_product[21:0];
               exp_p1    <= exp_in;
            end
            sign_p1          <= mul_sign;
            special_p1       <= mul_special;
            special_value_p1 <= mul_special_value;
            tag_p1           <= mul_tag;
         end
      end
   end

   logic [22:0]        mant_rnd;
   logic               carry;
   logic signed [10:0] exp_fin;
   fp_pack_t           packed_p1;

   fp_round_nearest_even #(.WIDTH(FLOAT32_SIG_WIDTH)) u_round (
      .mant         (mant_p1),
      .guard        (guard_p1),
      .sticky       (sticky_p1),
      .mant_rounded (mant_rnd),
      .carry        (carry)
   );

   // A rounding carry leaves mant_rnd at zero, which is the correct 1.0 fraction
   assign exp_fin   = exp_p1 + $signed({10'b0, carry});
   assign packed_p1 = pack_result(sign_p1, exp_fin, mant_rnd, guard_p1 | sticky_p1);

   // Stage 2: round, saturate and pack
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_valid     <= 1'b0;
         result           <= '0;
         result_tag       <= '0;
         result_overflow  <= 1'b0;
         result_underflow <= 1'b0;
         result_inexact   <= 1'b0;
      end else begin
         result_valid <= vld_p1 & ~flush;
         if (vld_p1) begin
            result_tag <= tag_p1;
            if (special_p1) begin
               result           <= special_value_p1;
               result_overflow  <= 1'b0;
               result_underflow <= 1'b0;
               result_inexact   <= 1'b0;
            end else begin
               result           <= packed_p1.value;
               result_overflow  <= packed_p1.overflow;
               result_underflow <= packed_p1.underflow;
               result_inexact   <= packed_p1.inexact;
            end
         end
      end
   end

endmodule
